// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] SEC_TENS_MAX          = 4'd5;
    localparam logic [3:0] DIGIT_MAX             = 4'd9;
    localparam int         DEFAULT_TICKS_PER_SEC = 100;

    // Per-digit saturation so an out-of-range preset becomes legal BCD time.
    function automatic logic [15:0] clamp_preset(input logic [15:0] p);
        logic [15:0] c;
        c[15:12] = (p[15:12] > DIGIT_MAX)    ? DIGIT_MAX    : p[15:12];
        c[11:8]  = (p[11:8]  > DIGIT_MAX)    ? DIGIT_MAX    : p[11:8];
        c[7:4]   = (p[7:4]   > SEC_TENS_MAX) ? SEC_TENS_MAX : p[7:4];
        c[3:0]   = (p[3:0]   > DIGIT_MAX)    ? DIGIT_MAX    : p[3:0];
        return c;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control and display bundle between the timer and its controller/display.
interface countdown_timer_if;
    logic        tick;
    logic        load;
    logic [15:0] preset;
    logic        start;
    logic        pause;
    logic        clear;
    logic [15:0] time_bcd;
    logic        running;
    logic        done;
    logic        alarm;

    modport master (
        output tick, load, preset, start, pause, clear,
        input  time_bcd, running, done, alarm
    );

    modport slave (
        input  tick, load, preset, start, pause, clear,
        output time_bcd, running, done, alarm
    );
endinterface

// File: rtl/bcd_digit_down.sv
// One BCD digit of the down-counting chain; wraps 0 -> MAX and borrows.
module bcd_digit_down #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic [3:0] i_digit,
    input  logic       i_dec,
    output logic [3:0] o_next,
    output logic       o_borrow
);
    assign o_borrow = i_dec && (i_digit == 4'd0);
    assign o_next   = !i_dec             ? i_digit :
                      (i_digit == 4'd0)  ? MAX     :
                                           (i_digit - 4'd1);
endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer: tick prescaler, control FSM and borrow chain.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC
) (
    input  logic                clk,
    input  logic                rst,
    countdown_timer_if.slave    bus
);
    localparam logic [9:0] PRESC_LAST = 10'(TICKS_PER_SEC - 1);

    state_t      r_state;
    logic [9:0]  r_presc;
    logic [15:0] r_time;
    logic        r_running;
    logic        r_done;
    logic        r_alarm;

    state_t      w_state_nx;
    logic [9:0]  w_presc_nx;
    logic [15:0] w_time_nx;
    logic        w_done_nx;
    logic        w_dec_en;
    logic [15:0] w_dec_time;
    logic [3:0]  w_borrow;
    logic [15:0] w_clamped;

    assign w_clamped = clamp_preset(bus.preset);

    // A second elapses only on the last prescaler tick in RUN with no overriding control.
    assign w_dec_en = (r_state == RUN) && !bus.clear && !bus.pause && bus.tick &&
                      (r_presc == PRESC_LAST) && (r_time != 16'h0000);

    bcd_digit_down #(.MAX(DIGIT_MAX)) u_sec_ones (
        .i_digit(r_time[3:0]),   .i_dec(w_dec_en),
        .o_next(w_dec_time[3:0]),   .o_borrow(w_borrow[0])
    );
    bcd_digit_down #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .i_digit(r_time[7:4]),   .i_dec(w_borrow[0]),
        .o_next(w_dec_time[7:4]),   .o_borrow(w_borrow[1])
    );
    bcd_digit_down #(.MAX(DIGIT_MAX)) u_min_ones (
        .i_digit(r_time[11:8]),  .i_dec(w_borrow[1]),
        .o_next(w_dec_time[11:8]),  .o_borrow(w_borrow[2])
    );
    bcd_digit_down #(.MAX(DIGIT_MAX)) u_min_tens (
        .i_digit(r_time[15:12]), .i_dec(w_borrow[2]),
        .o_next(w_dec_time[15:12]), .o_borrow(w_borrow[3])
    );

    // Next-state, next-time and prescaler decisions with clear > load > start > pause.
    always_comb begin
        w_state_nx = r_state;
        w_time_nx  = r_time;
        w_presc_nx = r_presc;
        w_done_nx  = 1'b0;
        if (bus.clear) begin
            w_state_nx = IDLE;
            w_time_nx  = 16'h0000;
            w_presc_nx = 10'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.load) begin
                        w_time_nx = w_clamped;
                    end else if (bus.start && (r_time != 16'h0000)) begin
                        w_state_nx = RUN;
                        w_presc_nx = 10'd0;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        w_state_nx = PAUSE;
                    end else if (bus.tick) begin
                        if (r_presc == PRESC_LAST) begin
                            w_presc_nx = 10'd0;
                            w_time_nx  = w_dec_time;
                            if (w_dec_time == 16'h0000) begin
                                w_state_nx = DONE;
                                w_done_nx  = 1'b1;
                            end else begin
                                w_state_nx = RUN;
                            end
                        end else begin
                            w_presc_nx = r_presc + 10'd1;
                        end
                    end else begin
                        w_state_nx = RUN;
                    end
                end
                PAUSE: begin
                    if (bus.start) begin
                        w_state_nx = RUN;
                    end else begin
                        w_state_nx = PAUSE;
                    end
                end
                DONE: begin
                    if (bus.load) begin
                        w_state_nx = IDLE;
                        w_time_nx  = w_clamped;
                    end else begin
                        w_state_nx = DONE;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                    w_time_nx  = 16'h0000;
                    w_presc_nx = 10'd0;
                end
            endcase
        end
    end

    // State, time, prescaler and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_time    <= 16'h0000;
            r_presc   <= 10'd0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_time    <= w_time_nx;
            r_presc   <= w_presc_nx;
            r_running <= (w_state_nx == RUN);
            r_done    <= w_done_nx;
            r_alarm   <= (w_state_nx == DONE);
        end
    end

    assign bus.time_bcd = r_time;
    assign bus.running  = r_running;
    assign bus.done     = r_done;
    assign bus.alarm    = r_alarm;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer (TICKS_PER_SEC=2) with an expected-time scoreboard.
module tb_countdown_timer;
    logic clk;
    logic rst;
    countdown_timer_if bus ();

    countdown_timer #(.TICKS_PER_SEC(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    logic [15:0] exp_q[$];

    always @(posedge clk) begin
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_time(input logic [15:0] t);
        exp_q.push_back(t);
    endtask

    task automatic pop_time(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed empty-scoreboard expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, bus.time_bcd, e);
        end
    endtask

    // One clock; pulse inputs drop after the edge, outputs are sampled 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
        bus.tick  = 1'b0;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.clear = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            cyc();
        end
    endtask

    task automatic do_load(input logic [15:0] p);
        bus.load   = 1'b1;
        bus.preset = p;
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        bus.tick = 1'b0; bus.load = 1'b0; bus.preset = 16'h0000;
        bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        push_time(16'h0000); pop_time("reset_time");
        chk("reset_running", {15'd0, bus.running}, 16'd0);
        chk("reset_done",    {15'd0, bus.done},    16'd0);
        chk("reset_alarm",   {15'd0, bus.alarm},   16'd0);

        // Basic countdown 00:03
        do_load(16'h0003);
        push_time(16'h0003); pop_time("load_0003");
        bus.start = 1'b1; cyc();
        chk("start_running", {15'd0, bus.running}, 16'd1);
        ticks(2); push_time(16'h0002); pop_time("count_0002");
        ticks(2); push_time(16'h0001); pop_time("count_0001");
        ticks(1); push_time(16'h0001); pop_time("half_second");
        ticks(1); push_time(16'h0000); pop_time("count_0000");
        chk("done_pulse",    {15'd0, bus.done},    16'd1);
        chk("alarm_on",      {15'd0, bus.alarm},   16'd1);
        chk("run_off_done",  {15'd0, bus.running}, 16'd0);
        cyc();
        chk("done_one_cycle", {15'd0, bus.done},  16'd0);
        chk("alarm_held",     {15'd0, bus.alarm}, 16'd1);
        chk("done_count",     16'(done_cnt),      16'd1);

        // Borrow chain
        do_load(16'h1000);
        push_time(16'h1000); pop_time("load_from_done");
        chk("alarm_cleared", {15'd0, bus.alarm}, 16'd0);
        bus.start = 1'b1; cyc();
        ticks(2); push_time(16'h0959); pop_time("borrow_1000");
        bus.clear = 1'b1; cyc();
        do_load(16'h0100);
        bus.start = 1'b1; cyc();
        ticks(2); push_time(16'h0059); pop_time("borrow_0100");

        // Clamp and zero start
        bus.clear = 1'b1; cyc();
        do_load(16'hA9F9);
        push_time(16'h9959); pop_time("clamp_a9f9");
        bus.clear = 1'b1; cyc();
        push_time(16'h0000); pop_time("clear_time");
        bus.start = 1'b1; cyc();
        chk("zero_start_idle", {15'd0, bus.running}, 16'd0);

        // Priority: clear beats start in RUN
        do_load(16'h0230);
        bus.start = 1'b1; cyc();
        bus.clear = 1'b1; bus.start = 1'b1; cyc();
        push_time(16'h0000); pop_time("clear_over_start");
        chk("clear_stops", {15'd0, bus.running}, 16'd0);

        // Load ignored in RUN; tick with pause is dropped
        do_load(16'h0010);
        bus.start = 1'b1; cyc();
        bus.preset = 16'h0020; bus.load = 1'b1; cyc();
        push_time(16'h0010); pop_time("load_in_run");
        ticks(1);
        bus.tick = 1'b1; bus.pause = 1'b1; cyc();
        push_time(16'h0010); pop_time("tick_pause_drop");
        chk("paused", {15'd0, bus.running}, 16'd0);
        bus.start = 1'b1; cyc();
        ticks(1); push_time(16'h0009); pop_time("resume_after_drop");

        // Pause keeps the partial second
        bus.clear = 1'b1; cyc();
        do_load(16'h0005);
        bus.start = 1'b1; cyc();
        ticks(1);
        bus.pause = 1'b1; cyc();
        ticks(10); push_time(16'h0005); pop_time("held_in_pause");
        bus.start = 1'b1; cyc();
        chk("resumed", {15'd0, bus.running}, 16'd1);
        ticks(1); push_time(16'h0004); pop_time("partial_resume");

        // Reset mid-run
        bus.clear = 1'b1; cyc();
        do_load(16'h0230);
        bus.start = 1'b1; cyc();
        rst = 1'b1; bus.tick = 1'b1; bus.start = 1'b1; cyc();
        rst = 1'b0;
        push_time(16'h0000); pop_time("rst_mid_run");
        chk("rst_running", {15'd0, bus.running}, 16'd0);
        chk("rst_no_done", {15'd0, bus.done},    16'd0);
        cyc();
        chk("done_total", 16'(done_cnt), 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Minutes:seconds countdown timer that consumes the one-cycle tick produced by the 100 Hz tick generator. It divides that tick down to whole seconds and decrements a BCD MM:SS value from a loaded preset to 00:00. It provides start/pause/clear control and a completion pulse plus alarm level. BCD outputs drive the seven-segment display mux directly.

## Interface
- `TICKS_PER_SEC`, default 100: tick pulses per decremented second (range 1–1023).
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: one-cycle enable pulse from the 100 Hz generator; never assumed periodic.
- `load` in 1: one-cycle pulse; captures `preset` when state is IDLE or DONE.
- `preset` in 16: BCD {min_tens, min_ones, sec_tens, sec_ones}.
- `start` in 1: one-cycle pulse; begin or resume counting.
- `pause` in 1: one-cycle pulse; freeze counting.
- `clear` in 1: one-cycle pulse; abort to IDLE with time 00:00.
- `time_bcd` out 16: current MM:SS in BCD, registered.
- `running` out 1: high in RUN.
- `done` out 1: one-cycle pulse on reaching 00:00.
- `alarm` out 1: high while in DONE.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset → IDLE, `time_bcd`=0x0000, prescaler=0, all outputs 0.
- Control priority within a cycle: clear > load > start > pause. Only the winning control acts.
- IDLE:
  - `load` latches the clamped preset.
  - `start` with time ≠ 00:00 → RUN, prescaler cleared to 0.
  - `start` with time = 00:00 is ignored and stays in IDLE.
- RUN:
  - Each `tick` increments the prescaler. At the tick that would make it TICKS_PER_SEC, the prescaler returns to 0 and time decrements by one second.
  - If the decrement yields 00:00 → DONE and `done` pulses.
  - `pause` → PAUSE. A tick in the same cycle is dropped.
  - `load` is ignored.
- PAUSE:
  - Time and prescaler are held, and `tick` is ignored.
  - `start` → RUN with the prescaler NOT cleared, so the partial second resumes.
  - `load` and `pause` are ignored.
- DONE:
  - `alarm`=1 and time is 00:00.
  - `load` → IDLE with the new preset.
  - `start` is ignored.
- `clear` from any state → IDLE, time 00:00, prescaler 0, `alarm` low next cycle.
- Preset clamping is per digit: sec_tens >5 → 5; every other digit >9 → 9. Maximum value is 99:59.
- BCD decrement chain:
  - sec_ones 0→9 with borrow.
  - sec_tens 0→5 with borrow.
  - min_ones 0→9 with borrow.
  - min_tens decrements on borrow.
  - 00:00 is never decremented, so there is no wrap to 99:59.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- `load` at edge N → `time_bcd` shows the preset after edge N.
- `start` at edge N → `running`=1 after edge N. The first decrement occurs on the TICKS_PER_SEC-th tick seen in RUN.
- Decrementing tick sampled at edge N → new `time_bcd` after edge N.
- Final decrement to 00:00 at edge N → `done`=1 for exactly cycle N+1, `alarm`=1 from N+1, `running`=0 from N+1.
- `rst` asserted mid-count → IDLE on the next edge regardless of other inputs. `done` is never emitted by reset.
- Back-to-back `tick` on consecutive cycles must be counted individually.

## Structure
- Shared package `timer_pkg`:
  - state enum (IDLE, RUN, PAUSE, DONE)
  - BCD digit maxima constants (SEC_TENS_MAX=5, DIGIT_MAX=9)
  - default TICKS_PER_SEC
- Sub-module `bcd_digit_down`:
  - parameter MAX
  - inputs: digit, decrement enable
  - outputs: next digit, borrow-out
  - Instantiated four times in a borrow chain.
- Top level holds the FSM, prescaler, and preset clamp.

## Test plan
- Basic countdown (TICKS_PER_SEC=2): reset, load 0x0003, start, 6 ticks → `time_bcd` goes 0x0002, 0x0001, 0x0000. `done` pulses once. `alarm`=1.
- Borrow chain: load 0x1000, start, 2 ticks → 0x0959. Load 0x0100, run 1 s → 0x0059.
- Pause/resume keeps partial second (TICKS_PER_SEC=4): load 0x0005, start, 2 ticks, pause, 10 ticks, start, 2 ticks → 0x0004 (time unchanged during pause).
- Clamp and zero start: load 0xA9F9 → 0x9959. Clear, then start at 00:00 → `running` stays 0.
- Priority and ignored controls:
  - `clear`+`start` in the same cycle in RUN → IDLE, 0x0000.
  - `load` in RUN leaves time unchanged.
  - `tick`+`pause` in the same cycle → no prescaler advance.
- Reset mid-run: `rst` at 0x0230 in RUN → next cycle 0x0000, `running`=0, no `done`.
